ula_arbiter: RTL
================

Name: ula_arbiter

Overview:
- Shares one combinational ULA instance (ULA_OP-bit opcode, BITS-bit operands) between two requesters, e.g. the execute stage and an address/immediate helper.
- Accepts one operation at a time with a valid/ready handshake and picks between the requesters round-robin.
- Registers the operands that drive the ULA and captures the ULA result into a shared result register.
- Signals completion with a one-cycle done pulse to the requester that was granted.

Parameters:
- ULA_OP, 3, opcode width; must match the ULA instance.
- BITS, 8, data width of operands and result.

Ports:
- clk_in  input  1  clock; all state updates on the rising edge.
- rst_in  input  1  reset; synchronous, active-high.
- req0_valid_in  input  1  requester 0 has an operation pending.
- req0_op_in  input  ULA_OP  requester 0 opcode.
- req0_a_in  input  BITS  requester 0 operand A.
- req0_b_in  input  BITS  requester 0 operand B.
- req0_ready_out  output  1  requester 0 operation accepted this cycle.
- req0_done_out  output  1  one-cycle pulse: result_out holds requester 0's result.
- req1_valid_in, req1_op_in, req1_a_in, req1_b_in, req1_ready_out, req1_done_out  same widths and meaning, for requester 1.
- result_out  output  BITS  last captured ULA result.
- busy_out  output  1  high while an accepted operation has not yet completed.
- ula_op_out  output  ULA_OP  registered opcode to the ULA.
- ula_a_out  output  BITS  registered operand A to the ULA.
- ula_b_out  output  BITS  registered operand B to the ULA.
- ula_result_in  input  BITS  ULA combinational result.

Behaviour:
- FSM states: IDLE and EXEC. Reset state is IDLE.
- Reset values: result_out=0, done outputs=0, busy_out=0, ula_op/a/b_out=0, last_grant=1 (so requester 0 has priority first).
- Ready outputs are combinational:
  - readyX = 1 only in IDLE, when reqX_valid_in=1 and X is the selected grant.
  - At most one ready is high in any cycle.
- Grant selection in IDLE:
  - Only one valid: grant that requester.
  - Both valid: grant the requester != last_grant.
  - None valid: stay in IDLE, no ready asserted.
- Accept, cycle N (IDLE with a handshake):
  - Register the granted op/a/b into ula_op/a/b_out.
  - last_grant <= granted id.
  - Go to EXEC.
- EXEC, cycle N+1:
  - ula_result_in is valid, because the ULA is driven by the registered operands.
  - result_out <= ula_result_in.
  - reqX_done_out <= 1 for the granted X; the other done output <= 0.
  - Go to IDLE.
- Cycle N+2:
  - done pulse is high and result_out is valid.
  - FSM is in IDLE and may accept a new request in this same cycle.
  - Throughput: 1 operation per 2 cycles. Latency from acceptance to done: 2 cycles.
- Done outputs are high for exactly one cycle; they clear on the following edge unless another EXEC completes.
- busy_out = (state == EXEC), registered.
- result_out holds its value until the next EXEC; ula_*_out hold the last accepted operands while idle.
- Requesters must hold valid, op, a and b stable until ready. Dropping valid before ready is legal; the request is then simply never accepted.
- Arithmetic: the arbiter never modifies data. Wrap-around, shift width and every other arithmetic rule belong to the ULA. result_out is exactly BITS bits.
- Reset asserted in any state, including mid-EXEC:
  - All state returns to reset values on that edge.
  - No done pulse is issued for the aborted operation.
  - No ready is asserted while rst_in=1.
- A valid arriving during EXEC is not acknowledged until the FSM is back in IDLE.

Test Plan:
- Single add: after reset, req0 valid, op=100, a=0x05, b=0x03 -> req0_ready high in cycle N, busy in N+1, req0_done pulse in N+2 with result_out=0x08; req1_done stays 0.
- Simultaneous requests: after reset, req0 AND (0xF0, 0x3C) and req1 SUB (0x10, 0x20) both valid -> req0 granted first, result 0x30 with done0; then req1 granted in the done0 cycle, result 0xF0 with done1 two cycles later.
- Fairness: both requesters held valid for 8 operations -> grants alternate 0,1,0,1,…; a requester that alone stays valid (req1 with req0 idle) is granted every time.
- Wrap-around passthrough: req1 ADD (0xFF, 0x01) -> result_out=0x00; req0 SHL (0x81, 0x01) -> 0x02.
- Reset mid-operation: assert rst_in during EXEC -> no done pulse, result_out=0, busy_out=0 next cycle; a later request completes normally.
- Back-to-back timing: req0 held valid with a new op each acceptance -> ready asserted every second cycle, coinciding with the previous operation's done pulse.

Source files
------------

// File: rtl/ula_arbiter.sv
// Round-robin arbiter sharing one combinational ULA between two requesters.
// Operands are registered toward the ULA; the result is captured one cycle later.
module ula_arbiter #(
   parameter int ULA_OP = 3,
   parameter int BITS   = 8
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              req0_valid_in,
   input  logic [ULA_OP-1:0] req0_op_in,
   input  logic [BITS-1:0]   req0_a_in,
   input  logic [BITS-1:0]   req0_b_in,
   output logic              req0_ready_out,
   output logic              req0_done_out,
   input  logic              req1_valid_in,
   input  logic [ULA_OP-1:0] req1_op_in,
   input  logic [BITS-1:0]   req1_a_in,
   input  logic [BITS-1:0]   req1_b_in,
   output logic              req1_ready_out,
   output logic              req1_done_out,
   output logic [BITS-1:0]   result_out,
   output logic              busy_out,
   output logic [ULA_OP-1:0] ula_op_out,
   output logic [BITS-1:0]   ula_a_out,
   output logic [BITS-1:0]   ula_b_out,
   input  logic [BITS-1:0]   ula_result_in
);

   typedef enum logic {IDLE, EXEC} state_t;

   state_t state;
   logic   last_grant;
   logic   sel;
   logic   accept;

   // sel: 0 picks requester 0, 1 picks requester 1; only the other one when both contend
   always_comb begin
      sel = 1'b0;
      if (req0_valid_in && req1_valid_in)
         sel = ~last_grant;
      else if (req1_valid_in)
         sel = 1'b1;
      accept         = (state == IDLE) && !rst_in && (req0_valid_in || req1_valid_in);
      req0_ready_out = accept && !sel;
      req1_ready_out = accept && sel;
   end

   assign busy_out = (state == EXEC);

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state         <= IDLE;
         last_grant    <= 1'b1;
         result_out    <= '0;
         req0_done_out <= 1'b0;
         req1_done_out <= 1'b0;
         ula_op_out    <= '0;
         ula_a_out     <= '0;
         ula_b_out     <= '0;
      end else begin
         case (state)
            IDLE: begin
               req0_done_out <= 1'b0;
               req1_done_out <= 1'b0;
               if (accept) begin
                  ula_op_out <= sel ? req1_op_in : req0_op_in;
                  ula_a_out  <= sel ? req1_a_in  : req0_a_in;
                  ula_b_out  <= sel ? req1_b_in  : req0_b_in;
                  last_grant <= sel;
                  state      <= EXEC;
               end
            end
            EXEC: begin
               // last_grant still names the requester whose operands are at the ULA
               result_out    <= ula_result_in;
               req0_done_out <= ~last_grant;
               req1_done_out <= last_grant;
               state         <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
